// File: rtl/shift_add_multiplier_eight_bit_if.sv
// Handshake and operand bundle for the shift-add multiplier.
// Requester drives start/a/b; the multiplier returns busy/done/product.
interface shift_add_multiplier_eight_bit_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier_eight_bit.sv
// Sequential 8x8 unsigned shift-add multiplier.
// One adder pass per cycle, 8 iterations, one-cycle done pulse.
module adder_subractor_eight_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       m,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] b_eff;

    // m=1 turns the add into a two's-complement subtract
    always_comb begin
        b_eff = b ^ {8{m}};
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {8'h00, cin};
    end
endmodule

module shift_add_multiplier_eight_bit (
    input  logic clk,
    input  logic rst_n,
    shift_add_multiplier_eight_bit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] mcand;
    logic [7:0] acc_hi;
    logic [7:0] mplier;
    logic [2:0] count;
    logic [7:0] sum;
    logic       cout;
    logic [7:0] hi;
    logic       c;

    adder_subractor_eight_bit u_add (
        .a    (acc_hi),
        .b    (mcand),
        .m    (1'b0),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Take the adder result only when the current multiplier bit is set
    always_comb begin
        hi = acc_hi;
        c  = 1'b0;
        if (mplier[0]) begin
            hi = sum;
            c  = cout;
        end
    end

    // Control FSM, shift datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mcand       <= 8'h00;
            acc_hi      <= 8'h00;
            mplier      <= 8'h00;
            count       <= 3'd0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        mcand    <= bus.a;
                        mplier   <= bus.b;
                        acc_hi   <= 8'h00;
                        count    <= 3'd0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= {c, hi[7:1]};
                    mplier <= {hi[0], mplier[7:1]};
                    count  <= count + 3'd1;
                    if (count == 3'd7) begin
                        bus.product <= {c, hi, mplier[7:1]};
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier_eight_bit.sv
// Self-checking bench for shift_add_multiplier_eight_bit.
// Directed cases plus random operands against plain a*b.
module tb_shift_add_multiplier_eight_bit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    shift_add_multiplier_eight_bit_if bus ();

    shift_add_multiplier_eight_bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // advance until done is seen or the budget runs out
    task automatic wait_done(input int budget, output int n,
                             output int busy_n);
        n = 0;
        busy_n = 0;
        while (!bus.done && n < budget) begin
            if (bus.busy) busy_n++;
            step();
            n++;
        end
    endtask

    // full operation from a start pulse; expected value is plain a*b
    task automatic run_op(input logic [7:0] ea, input logic [7:0] eb,
                          input string tag);
        int n;
        int bn;
        logic [15:0] exp_p;
        exp_p = 16'(ea) * 16'(eb);
        bus.a = ea;
        bus.b = eb;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        wait_done(20, n, bn);
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_busy_cycles"}, bn, 8);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_product"}, bus.product, exp_p);
        step();
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_hold"}, bus.product, exp_p);
    endtask

    initial begin
        int n;
        int bn;
        int dones;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_product", bus.product, 0);
        step();
        step();
        #3 rst_n = 1'b1;
        step();
        chk("idle_busy", bus.busy, 0);

        run_op(8'd0, 8'd123, "zero");
        run_op(8'd15, 8'd15, "m15x15");
        run_op(8'd255, 8'd255, "m255x255");

        // start re-pulsed mid-operation must be ignored
        bus.a = 8'd200;
        bus.b = 8'd55;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 3 || i == 5) begin
                bus.a = 8'd1;
                bus.b = 8'd1;
                bus.start = 1'b1;
            end
            step();
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                chk("ignore_product", bus.product, 11000);
            end
        end
        chk("ignore_one_done", dones, 1);
        chk("ignore_hold", bus.product, 11000);

        // asynchronous reset in the middle of RUN
        bus.a = 8'd100;
        bus.b = 8'd50;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_product", bus.product, 0);
        step();
        step();
        #2 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run_op(8'd7, 8'd3, "after_rst");

        // start held high: back-to-back accepts
        bus.a = 8'd10;
        bus.b = 8'd5;
        bus.start = 1'b1;
        step();
        wait_done(20, n, bn);
        chk("b2b_first_lat", n, 8);
        chk("b2b_first_product", bus.product, 50);
        bus.a = 8'd128;
        bus.b = 8'd2;
        step();
        chk("b2b_gap_done", bus.done, 0);
        wait_done(20, n, bn);
        chk("b2b_second_gap", n + 1, 10);
        chk("b2b_second_product", bus.product, 256);
        bus.start = 1'b0;
        step();
        step();
        step();
        chk("b2b_idle", bus.busy, 0);

        // random operands against plain multiplication
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
